// File: rtl/csa_sub_pipe.sv
// csa_sub_pipe: pipelined carry-select subtractor, a - b - borrow_in, one SLICE-bit slice per stage
module csa_sub_pipe #(
  parameter int WIDTH = 16,
  parameter int SLICE = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             borrow_in,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] diff,
  output logic             borrow_out,
  output logic             ovf,
  output logic             zero
);
  localparam int NS = WIDTH / SLICE;
  logic en;
  assign en = !out_valid || out_ready;
  assign in_ready = en && !rst;
  genvar k;
  for (k = 0; k < NS; k++) begin : st
    localparam int R = WIDTH - (k + 1) * SLICE;
    logic vi, bi, ami, bmi, v, bw;
    logic [SLICE-1:0] sa, sb;
    logic [SLICE:0] s0, s1, sel;
    logic [(k+1)*SLICE-1:0] di, d;
    if (k == 0) begin : src
      assign vi  = in_valid;
      assign bi  = borrow_in;
      assign ami = a[WIDTH-1];
      assign bmi = b[WIDTH-1];
      assign sa  = a[SLICE-1:0];
      assign sb  = b[SLICE-1:0];
      assign di  = sel[SLICE-1:0];
    end else begin : src
      assign vi  = st[k-1].v;
      assign bi  = st[k-1].bw;
      assign ami = st[k-1].rem.am;
      assign bmi = st[k-1].rem.bm;
      assign sa  = st[k-1].rem.ra[SLICE-1:0];
      assign sb  = st[k-1].rem.rb[SLICE-1:0];
      assign di  = {sel[SLICE-1:0], st[k-1].d};
    end
    // both candidates share a + ~b; the incoming borrow only picks one
    assign s0  = {1'b0, sa} + {1'b0, ~sb};
    assign s1  = s0 + {{SLICE{1'b0}}, 1'b1};
    assign sel = bi ? s0 : s1;
    always_ff @(posedge clk)
      if (rst) begin
        v  <= 1'b0;
        bw <= 1'b0;
        d  <= '0;
      end else if (en) begin
        v  <= vi;
        bw <= ~sel[SLICE];
        d  <= di;
      end
    if (k < NS - 1) begin : rem
      logic [R-1:0] ra, rb, rai, rbi;
      logic am, bm;
      if (k == 0) begin : s
        assign rai = a[WIDTH-1:SLICE];
        assign rbi = b[WIDTH-1:SLICE];
      end else begin : s
        assign rai = st[k-1].rem.ra[R+SLICE-1:SLICE];
        assign rbi = st[k-1].rem.rb[R+SLICE-1:SLICE];
      end
      always_ff @(posedge clk)
        if (rst) begin
          ra <= '0;
          rb <= '0;
          am <= 1'b0;
          bm <= 1'b0;
        end else if (en) begin
          ra <= rai;
          rb <= rbi;
          am <= ami;
          bm <= bmi;
        end
    end
  end
  // flags are derived from the final stage inputs so they register alongside diff
  always_ff @(posedge clk)
    if (rst) begin
      ovf  <= 1'b0;
      zero <= 1'b0;
    end else if (en) begin
      ovf  <= (st[NS-1].ami != st[NS-1].bmi) && (st[NS-1].di[WIDTH-1] != st[NS-1].ami);
      zero <= st[NS-1].di == '0;
    end
  assign diff       = st[NS-1].d;
  assign borrow_out = st[NS-1].bw;
  assign out_valid  = st[NS-1].v;
endmodule

// File: tb/tb_csa_sub_pipe.sv
// tb_csa_sub_pipe: scoreboard bench for csa_sub_pipe against an arithmetic reference model
module tb_csa_sub_pipe;
  logic clk = 1'b0;
  logic rst, in_valid, in_ready, borrow_in, out_valid, out_ready, borrow_out, ovf, zero;
  logic [15:0] a, b, diff;
  typedef struct packed {
    logic [15:0] d;
    logic bo;
    logic ov;
    logic z;
  } exp_t;
  exp_t q[$];
  int n_cmp = 0;
  int n_bad = 0;
  always #5 clk = ~clk;
  csa_sub_pipe #(.WIDTH(16), .SLICE(4)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .borrow_in(borrow_in), .out_valid(out_valid), .out_ready(out_ready),
    .diff(diff), .borrow_out(borrow_out), .ovf(ovf), .zero(zero)
  );
  function automatic exp_t model(input logic [15:0] x, input logic [15:0] y, input logic c);
    exp_t e;
    logic [16:0] f;
    f    = {1'b0, x} - {1'b0, y} - {16'h0, c};
    e.d  = f[15:0];
    e.bo = f[16];
    e.ov = (x[15] != y[15]) && (f[15] != x[15]);
    e.z  = f[15:0] == 16'h0;
    return e;
  endfunction
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    n_cmp++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, act, req);
    end
  endtask
  task automatic step(input logic v, input logic [15:0] x, input logic [15:0] y, input logic c,
                      input logic ordy, input exp_t e, output logic acc);
    @(negedge clk);
    in_valid = v; a = x; b = y; borrow_in = c; out_ready = ordy;
    #1;
    acc = in_valid && in_ready;
    if (acc) q.push_back(e);
  endtask
  task automatic send(input logic [15:0] x, input logic [15:0] y, input logic c, input exp_t e);
    logic acc;
    int n;
    n = 0;
    do begin
      step(1'b1, x, y, c, 1'b1, e, acc);
      n++;
    end while (!acc && n < 50);
    if (!acc) begin
      n_cmp++;
      n_bad++;
      $display("FAIL send: operands not accepted within 50 cycles");
    end
  endtask
  task automatic idle(input int n);
    logic acc;
    for (int i = 0; i < n; i++) step(1'b0, 16'h0, 16'h0, 1'b0, 1'b1, '0, acc);
  endtask
  task automatic latency(input string name);
    int lat;
    lat = 0;
    for (int n = 1; n <= 12 && lat == 0; n++) begin
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      if (out_valid) lat = n;
    end
    chk(name, 32'(lat), 32'd4);
  endtask
  // monitor: pops the expected result whenever the DUT output is consumed
  initial begin
    logic stall;
    logic [19:0] prev;
    exp_t e, got;
    stall = 1'b0;
    prev = '0;
    forever begin
      @(negedge clk);
      #2;
      if (rst) stall = 1'b0;
      else begin
        if (stall) begin
          n_cmp++;
          if ({diff, borrow_out, ovf, zero} !== prev[19:1] || !out_valid) begin
            n_bad++;
            $display("FAIL stall_hold: got %h expected %h", {diff, borrow_out, ovf, zero}, prev[19:1]);
          end
        end
        if (out_valid && !out_ready) chk("stall_in_ready", 32'(in_ready), 32'd0);
        if (out_valid && out_ready) begin
          got = {diff, borrow_out, ovf, zero};
          n_cmp++;
          if (q.size() == 0) begin
            n_bad++;
            $display("FAIL result: got %h expected none (unexpected output)", got);
          end else begin
            e = q.pop_front();
            if (got !== e) begin
              n_bad++;
              $display("FAIL result: got d=%h bo=%b ov=%b z=%b expected d=%h bo=%b ov=%b z=%b",
                       got.d, got.bo, got.ov, got.z, e.d, e.bo, e.ov, e.z);
            end
          end
        end
        stall = out_valid && !out_ready;
        prev = {diff, borrow_out, ovf, zero, out_valid};
      end
    end
  end
  initial begin
    logic acc;
    logic [15:0] xa[8], xb[8];
    logic xc[8];
    logic [15:0] ra, rb;
    logic rc, ordy;
    int i, cyc;
    rst = 1'b1; in_valid = 1'b0; a = '0; b = '0; borrow_in = 1'b0; out_ready = 1'b1;
    repeat (2) @(negedge clk);
    chk("reset_state", {diff, borrow_out, ovf, zero, out_valid}, 32'h0);
    chk("reset_in_ready", 32'(in_ready), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("post_reset_in_ready", 32'(in_ready), 32'd1);
    send(16'h1234, 16'h0234, 1'b0, '{16'h1000, 1'b0, 1'b0, 1'b0});
    latency("basic_latency");
    send(16'h1000, 16'h0001, 1'b0, '{16'h0FFF, 1'b0, 1'b0, 1'b0});
    send(16'h0000, 16'h0001, 1'b0, '{16'hFFFF, 1'b1, 1'b0, 1'b0});
    send(16'h0000, 16'h0000, 1'b1, '{16'hFFFF, 1'b1, 1'b0, 1'b0});
    send(16'h8000, 16'h0001, 1'b0, '{16'h7FFF, 1'b0, 1'b1, 1'b0});
    send(16'h7FFF, 16'hFFFF, 1'b0, '{16'h8000, 1'b1, 1'b1, 1'b0});
    send(16'hABCD, 16'hABCD, 1'b0, '{16'h0000, 1'b0, 1'b0, 1'b1});
    idle(8);
    chk("directed_drained", 32'(q.size()), 32'd0);
    // backpressure: 8 back-to-back sets, consumer stalls in cycles 4..6
    for (int j = 0; j < 8; j++) begin
      xa[j] = 16'($urandom); xb[j] = 16'($urandom); xc[j] = 1'($urandom);
    end
    i = 0;
    cyc = 0;
    while (i < 8 && cyc < 40) begin
      ordy = !(cyc >= 4 && cyc <= 6);
      step(1'b1, xa[i], xb[i], xc[i], ordy, model(xa[i], xb[i], xc[i]), acc);
      chk("bp_in_ready", 32'(in_ready), 32'(ordy));
      if (acc) i++;
      cyc++;
    end
    idle(8);
    chk("bp_drained", 32'(q.size()), 32'd0);
    // reset mid-stream discards everything in flight
    for (int j = 0; j < 3; j++) begin
      ra = 16'($urandom); rb = 16'($urandom); rc = 1'($urandom);
      send(ra, rb, rc, model(ra, rb, rc));
    end
    @(negedge clk);
    rst = 1'b1; in_valid = 1'b1; out_ready = 1'b1;
    #1;
    chk("rst_in_ready", 32'(in_ready), 32'd0);
    q.delete();
    @(negedge clk);
    rst = 1'b0;
    ra = 16'($urandom); rb = 16'($urandom); rc = 1'($urandom);
    in_valid = 1'b1; a = ra; b = rb; borrow_in = rc;
    #1;
    chk("rst_outputs", {diff, borrow_out, ovf, zero, out_valid}, 32'h0);
    chk("rst_accept", 32'(in_ready), 32'd1);
    if (in_valid && in_ready) q.push_back(model(ra, rb, rc));
    latency("rst_latency");
    idle(8);
    chk("rst_drained", 32'(q.size()), 32'd0);
    // random regression
    for (int j = 0; j < 10000; j++) begin
      ra = 16'($urandom); rb = 16'($urandom); rc = 1'($urandom);
      step($urandom_range(3, 0) != 0, ra, rb, rc, $urandom_range(3, 0) != 0, model(ra, rb, rc), acc);
    end
    idle(10);
    chk("random_drained", 32'(q.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
